// File: rtl/wasm_mem_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// wasm_mem_if : byte-wide request/ready fetch port shared by core and memory
// Rev 1.0
//------------------------------------------------------------------------------
interface wasm_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read_en;
  logic [7:0]            mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_addr,
    output mem_read_en,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_read_en,
    output mem_rdata,
    output mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/wasm_stack_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// wasm_stack_core : byte-serial WASM fetch/LEB128 decode over an on-chip stack
// Rev 1.0
//------------------------------------------------------------------------------
module wasm_stack_core #(
  parameter int DATA_WIDTH    = 32,
  parameter int STACK_DEPTH   = 16,
  parameter int NUM_LOCALS    = 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_LEB_BYTES = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          entry_pc,
  wasm_mem_if.master                     mem,
  output logic                           halted,
  output logic                           trap,
  output logic [2:0]                     trap_code,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic [$clog2(STACK_DEPTH):0]   stack_count,
  output logic [DATA_WIDTH-1:0]          stack_top
);
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LOC_W = (NUM_LOCALS > 1) ? $clog2(NUM_LOCALS) : 1;
  localparam int LEB_W = $clog2(MAX_LEB_BYTES + 1);
  localparam int SH_W  = 8;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  localparam logic [7:0] OP_UNREACH = 8'h00, OP_NOP  = 8'h01, OP_END  = 8'h0B;
  localparam logic [7:0] OP_DROP    = 8'h1A, OP_LGET = 8'h20, OP_LSET = 8'h21;
  localparam logic [7:0] OP_CONST   = 8'h41, OP_EQZ  = 8'h45, OP_EQ   = 8'h46;
  localparam logic [7:0] OP_ADD     = 8'h6A, OP_SUB  = 8'h6B, OP_MUL  = 8'h6C;
  localparam logic [7:0] OP_AND     = 8'h71, OP_OR   = 8'h72, OP_XOR  = 8'h73;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_IMM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, mem_addr_q, mem_addr_d;
  logic                    mem_read_en_q, mem_read_en_d;
  logic [7:0]              opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [SH_W-1:0]         shift_q, shift_d;
  logic [LEB_W-1:0]        leb_cnt_q, leb_cnt_d;
  logic                    halted_q, halted_d, trap_q, trap_d;
  logic [2:0]              trap_code_q, trap_code_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [DATA_WIDTH-1:0]   stack_d [STACK_DEPTH];
  logic [DATA_WIDTH-1:0]   locals_q [NUM_LOCALS];
  logic [DATA_WIDTH-1:0]   locals_d [NUM_LOCALS];

  logic                    w_hs, w_idx_ok, w_fault;
  logic [2:0]              w_fault_code;
  logic [PTR_W-1:0]        w_top_ptr, w_sec_ptr, w_push_ptr;
  logic [LOC_W-1:0]        w_lidx;
  logic [DATA_WIDTH-1:0]   w_top, w_sec, w_bin, w_byte_val;

  assign w_hs       = mem_read_en_q && mem.mem_ready;
  assign w_top_ptr  = PTR_W'(count_q - CNT_ONE);
  assign w_sec_ptr  = PTR_W'(count_q - CNT_TWO);
  assign w_push_ptr = PTR_W'(count_q);
  assign w_top      = stack_q[w_top_ptr];
  assign w_sec      = stack_q[w_sec_ptr];
  assign w_idx_ok   = acc_q < DATA_WIDTH'(NUM_LOCALS);
  assign w_lidx     = LOC_W'(acc_q);
  assign w_byte_val = DATA_WIDTH'(mem.mem_rdata[6:0]) << shift_q;

  // Binary ops see a = second-from-top, b = top.
  always_comb begin
    w_bin = '0;
    case (opcode_q)
      OP_ADD:  w_bin = w_sec + w_top;
      OP_SUB:  w_bin = w_sec - w_top;
      OP_MUL:  w_bin = w_sec * w_top;
      OP_AND:  w_bin = w_sec & w_top;
      OP_OR:   w_bin = w_sec | w_top;
      OP_XOR:  w_bin = w_sec ^ w_top;
      OP_EQ:   w_bin = DATA_WIDTH'(w_sec == w_top);
      default: w_bin = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    mem_read_en_d = mem_read_en_q;
    opcode_d      = opcode_q;
    acc_d         = acc_q;
    shift_d       = shift_q;
    leb_cnt_d     = leb_cnt_q;
    halted_d      = halted_q;
    trap_d        = trap_q;
    trap_code_d   = trap_code_q;
    count_d       = count_q;
    stack_d       = stack_q;
    locals_d      = locals_q;
    w_fault       = 1'b0;
    w_fault_code  = 3'd0;

    case (state_q)
      S_IDLE: if (start) begin
        pc_d          = entry_pc;
        mem_addr_d    = entry_pc;
        mem_read_en_d = 1'b1;
        state_d       = S_FETCH;
      end
      S_FETCH: if (w_hs) begin
        opcode_d      = mem.mem_rdata;
        pc_d          = pc_q + ADDR_WIDTH'(1);
        mem_read_en_d = 1'b0;
        state_d       = S_DECODE;
      end
      S_DECODE: case (opcode_q)
        OP_CONST, OP_LGET, OP_LSET: begin
          acc_d         = '0;
          shift_d       = '0;
          leb_cnt_d     = '0;
          mem_addr_d    = pc_q;
          mem_read_en_d = 1'b1;
          state_d       = S_IMM;
        end
        OP_UNREACH, OP_NOP, OP_END, OP_DROP, OP_EQZ, OP_EQ,
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: state_d = S_EXEC;
        default: begin
          w_fault      = 1'b1;
          w_fault_code = 3'd3;
        end
      endcase
      S_IMM: if (w_hs) begin
        pc_d      = pc_q + ADDR_WIDTH'(1);
        leb_cnt_d = leb_cnt_q + LEB_W'(1);
        acc_d     = acc_q | w_byte_val;
        shift_d   = shift_q + SH_W'(7);
        if (mem.mem_rdata[7]) begin
          if (leb_cnt_d >= LEB_W'(MAX_LEB_BYTES)) begin
            w_fault      = 1'b1;
            w_fault_code = 3'd4;
          end else begin
            mem_addr_d = pc_d;
          end
        end else begin
          // Sign bit of the last group lands at bit shift_d-1; fill above it.
          if (opcode_q == OP_CONST && mem.mem_rdata[6])
            acc_d = acc_d | ({DATA_WIDTH{1'b1}} << shift_d);
          mem_read_en_d = 1'b0;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        mem_addr_d    = pc_q;
        mem_read_en_d = 1'b1;
        state_d       = S_FETCH;
        case (opcode_q)
          OP_UNREACH: begin w_fault = 1'b1; w_fault_code = 3'd1; end
          OP_NOP: ;
          OP_END: begin
            halted_d      = 1'b1;
            mem_read_en_d = 1'b0;
            mem_addr_d    = mem_addr_q;
            state_d       = S_HALT;
          end
          OP_DROP:
            if (count_q < CNT_ONE) begin w_fault = 1'b1; w_fault_code = 3'd2; end
            else count_d = count_q - CNT_ONE;
          OP_CONST:
            if (count_q == CNT_FULL) begin w_fault = 1'b1; w_fault_code = 3'd6; end
            else begin
              stack_d[w_push_ptr] = acc_q;
              count_d             = count_q + CNT_ONE;
            end
          OP_LGET:
            if (!w_idx_ok) begin w_fault = 1'b1; w_fault_code = 3'd5; end
            else if (count_q == CNT_FULL) begin w_fault = 1'b1; w_fault_code = 3'd6; end
            else begin
              stack_d[w_push_ptr] = locals_q[w_lidx];
              count_d             = count_q + CNT_ONE;
            end
          OP_LSET:
            if (!w_idx_ok) begin w_fault = 1'b1; w_fault_code = 3'd5; end
            else if (count_q < CNT_ONE) begin w_fault = 1'b1; w_fault_code = 3'd2; end
            else begin
              locals_d[w_lidx] = w_top;
              count_d          = count_q - CNT_ONE;
            end
          OP_EQZ:
            if (count_q < CNT_ONE) begin w_fault = 1'b1; w_fault_code = 3'd2; end
            else stack_d[w_top_ptr] = DATA_WIDTH'(w_top == '0);
          default:
            if (count_q < CNT_TWO) begin w_fault = 1'b1; w_fault_code = 3'd2; end
            else begin
              stack_d[w_sec_ptr] = w_bin;
              count_d            = count_q - CNT_ONE;
            end
        endcase
      end
      default: mem_read_en_d = 1'b0;
    endcase

    if (w_fault) begin
      trap_d        = 1'b1;
      trap_code_d   = w_fault_code;
      mem_read_en_d = 1'b0;
      mem_addr_d    = mem_addr_q;
      state_d       = S_TRAP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      mem_addr_q    <= '0;
      mem_read_en_q <= 1'b0;
      opcode_q      <= '0;
      acc_q         <= '0;
      shift_q       <= '0;
      leb_cnt_q     <= '0;
      halted_q      <= 1'b0;
      trap_q        <= 1'b0;
      trap_code_q   <= '0;
      count_q       <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      for (int i = 0; i < NUM_LOCALS; i++) locals_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_read_en_q <= mem_read_en_d;
      opcode_q      <= opcode_d;
      acc_q         <= acc_d;
      shift_q       <= shift_d;
      leb_cnt_q     <= leb_cnt_d;
      halted_q      <= halted_d;
      trap_q        <= trap_d;
      trap_code_q   <= trap_code_d;
      count_q       <= count_d;
      stack_q       <= stack_d;
      locals_q      <= locals_d;
    end
  end

  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_read_en = mem_read_en_q;
  assign halted          = halted_q;
  assign trap            = trap_q;
  assign trap_code       = trap_code_q;
  assign pc              = pc_q;
  assign stack_count     = count_q;
  assign stack_top       = (count_q == '0) ? '0 : w_top;
endmodule
`default_nettype wire

// File: tb/tb_wasm_stack_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_wasm_stack_core : program-level reference interpreter vs the core
// Rev 1.0
//------------------------------------------------------------------------------
module tb_wasm_stack_core;
  localparam int DEPTH  = 4;
  localparam int NL     = 8;
  localparam int MAXLEB = 5;

  logic        clk, rst, start;
  logic [31:0] entry_pc;
  logic        halted, trap;
  logic [2:0]  trap_code;
  logic [31:0] pc;
  logic [2:0]  stack_count;
  logic [31:0] stack_top;

  wasm_mem_if #(.ADDR_WIDTH(32)) mif ();

  wasm_stack_core #(
    .DATA_WIDTH(32), .STACK_DEPTH(DEPTH), .NUM_LOCALS(NL),
    .ADDR_WIDTH(32), .MAX_LEB_BYTES(MAXLEB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .entry_pc(entry_pc), .mem(mif),
    .halted(halted), .trap(trap), .trap_code(trap_code), .pc(pc),
    .stack_count(stack_count), .stack_top(stack_top)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    bit          is_op;
    int          cnt;
    logic [31:0] top;
  } fetch_t;

  logic [7:0]  mem [1024];
  logic [7:0]  prog [$];
  fetch_t      exp_q [$];
  int          checks = 0, errors = 0;
  bit          rnd_mode = 0, model_active = 0;
  string       cur_test = "init";
  bit          m_halt, m_trap;
  int          m_code, m_pc, m_cnt;
  logic [31:0] m_top;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_test, nm, act, exp);
    end
  endtask

  // Instruction-level reference: walks the program byte by byte and records
  // every fetch address plus the stack state seen at each opcode fetch.
  task automatic model_run(input int entry);
    int p, sh, n;
    bit done;
    bit [31:0] st [$];
    bit [31:0] loc [NL];
    bit [31:0] a, b, imm;
    logic [7:0] op, by;
    longint unsigned acc;
    fetch_t e;
    exp_q.delete();
    for (int i = 0; i < NL; i++) loc[i] = 0;
    p = entry; done = 0; m_halt = 0; m_trap = 0; m_code = 0;
    for (int step = 0; step < 200 && !done; step++) begin
      e.addr = p; e.is_op = 1; e.cnt = st.size();
      e.top = (st.size() != 0) ? st[$] : 32'd0;
      exp_q.push_back(e);
      op = mem[p & 1023]; p++;
      acc = 0;
      if (!(op inside {8'h00, 8'h01, 8'h0B, 8'h1A, 8'h20, 8'h21, 8'h41, 8'h45,
                       8'h46, 8'h6A, 8'h6B, 8'h6C, 8'h71, 8'h72, 8'h73})) begin
        m_trap = 1; m_code = 3; done = 1;
      end else if (op inside {8'h41, 8'h20, 8'h21}) begin
        sh = 0; n = 0;
        forever begin
          e.addr = p; e.is_op = 0; e.cnt = 0; e.top = 0;
          exp_q.push_back(e);
          by = mem[p & 1023]; p++; n++;
          acc |= 64'(by[6:0]) << sh;
          sh += 7;
          if (!by[7]) begin
            if (op == 8'h41 && by[6]) acc |= ~64'd0 << sh;
            break;
          end
          if (n >= MAXLEB) begin m_trap = 1; m_code = 4; done = 1; break; end
        end
      end
      if (!done) begin
        imm = acc[31:0];
        case (op)
          8'h00: begin m_trap = 1; m_code = 1; done = 1; end
          8'h01: ;
          8'h0B: begin m_halt = 1; done = 1; end
          8'h1A: if (st.size() < 1) begin m_trap = 1; m_code = 2; done = 1; end
                 else void'(st.pop_back());
          8'h41: if (st.size() == DEPTH) begin m_trap = 1; m_code = 6; done = 1; end
                 else st.push_back(imm);
          8'h20: if (imm >= NL) begin m_trap = 1; m_code = 5; done = 1; end
                 else if (st.size() == DEPTH) begin m_trap = 1; m_code = 6; done = 1; end
                 else st.push_back(loc[imm]);
          8'h21: if (imm >= NL) begin m_trap = 1; m_code = 5; done = 1; end
                 else if (st.size() < 1) begin m_trap = 1; m_code = 2; done = 1; end
                 else loc[imm] = st.pop_back();
          8'h45: if (st.size() < 1) begin m_trap = 1; m_code = 2; done = 1; end
                 else begin a = st.pop_back(); st.push_back({31'd0, a == 0}); end
          default:
            if (st.size() < 2) begin m_trap = 1; m_code = 2; done = 1; end
            else begin
              b = st.pop_back(); a = st.pop_back();
              case (op)
                8'h6A:   st.push_back(a + b);
                8'h6B:   st.push_back(a - b);
                8'h6C:   st.push_back(a * b);
                8'h71:   st.push_back(a & b);
                8'h72:   st.push_back(a | b);
                8'h73:   st.push_back(a ^ b);
                default: st.push_back({31'd0, a == b});
              endcase
            end
        endcase
      end
    end
    m_pc = p; m_cnt = st.size();
    m_top = (st.size() != 0) ? st[$] : 32'd0;
  endtask

  // Memory responder: 0..5 cycle latency in random mode, stray strobes while idle.
  initial begin
    int wait_left;
    wait_left = -1;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (mif.mem_ready) begin
        mif.mem_ready = 1'b0;
        wait_left = -1;
      end else if (mif.mem_read_en) begin
        if (wait_left < 0) wait_left = rnd_mode ? int'($urandom_range(0, 5)) : 0;
        if (wait_left == 0) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = mem[mif.mem_addr[9:0]];
        end else wait_left--;
      end else begin
        wait_left = -1;
        if (rnd_mode && $urandom_range(0, 3) == 0) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = 8'h6A;
        end
      end
    end
  end

  // Per-cycle compare against the reference fetch stream.
  initial begin
    logic [31:0] prev_addr;
    bit prev_en, prev_hs;
    fetch_t e;
    prev_addr = 0; prev_en = 0; prev_hs = 0;
    forever begin
      @(negedge clk);
      if (model_active && !rst) begin
        if (mif.mem_read_en && prev_en && !prev_hs) chk("addr_stable", mif.mem_addr, prev_addr);
        if (halted || trap) chk("stopped_read_en", mif.mem_read_en, 0);
        if (stack_count == 0) chk("empty_top", stack_top, 0);
        if (mif.mem_read_en && mif.mem_ready) begin
          if (exp_q.size() == 0) chk("fetch_avail", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("fetch_addr", mif.mem_addr, e.addr);
            chk("fetch_pc", pc, e.addr);
            if (e.is_op) begin
              chk("op_count", stack_count, e.cnt);
              chk("op_top", stack_top, e.top);
            end
          end
        end
      end
      prev_en = mif.mem_read_en;
      prev_hs = mif.mem_read_en && mif.mem_ready;
      prev_addr = mif.mem_addr;
    end
  end

  task automatic load(input int entry);
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    for (int i = 0; i < prog.size(); i++) mem[(entry + i) & 1023] = prog[i];
  endtask

  task automatic run(input string nm, input int entry, input bit rst_first,
                     input bit lh, input bit lt, input int lc, input int lpc,
                     input int lcnt, input logic [31:0] ltop);
    int cyc;
    cur_test = nm;
    if (rst_first) begin
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
    end
    load(entry);
    model_run(entry);
    model_active = 1;
    @(negedge clk); entry_pc = entry; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(halted || trap) && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("stopped", halted | trap, 1);
    repeat (3) @(negedge clk);
    chk("fetches_left", exp_q.size(), 0);
    chk("halted", halted, m_halt);   chk("halted_lit", halted, lh);
    chk("trap", trap, m_trap);       chk("trap_lit", trap, lt);
    chk("code", trap_code, m_code);  chk("code_lit", trap_code, lc);
    chk("pc", pc, m_pc);             chk("pc_lit", pc, lpc);
    chk("count", stack_count, m_cnt); chk("count_lit", stack_count, lcnt);
    chk("top", stack_top, m_top);    chk("top_lit", stack_top, ltop);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("sticky_pc", pc, m_pc);
    chk("sticky_stop", {halted, trap}, {m_halt, m_trap});
    chk("sticky_rd", mif.mem_read_en, 0);
    model_active = 0;
  endtask

  task automatic suite();
    prog = '{8'h41, 8'h05, 8'h41, 8'h07, 8'h6A, 8'h0B};
    run("add", 'h100, 1, 1, 0, 0, 'h106, 1, 32'd12);
    prog = '{8'h41, 8'h7F, 8'h0B};
    run("neg1", 'h100, 1, 1, 0, 0, 'h103, 1, 32'hFFFF_FFFF);
    prog = '{8'h41, 8'h80, 8'h01, 8'h0B};
    run("leb128", 'h100, 1, 1, 0, 0, 'h104, 1, 32'd128);
    prog = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
    run("leb_long", 'h100, 1, 0, 1, 4, 'h106, 0, 32'd0);
    prog = '{8'h6A};
    run("underflow", 'h100, 1, 0, 1, 2, 'h101, 0, 32'd0);
    prog = '{8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01};
    run("overflow", 'h100, 1, 0, 1, 6, 'h10A, 4, 32'd1);
    prog = '{8'h41, 8'h2A, 8'h21, 8'h03, 8'h20, 8'h03, 8'h20, 8'h03, 8'h46, 8'h0B};
    run("locals_eq", 'h100, 1, 1, 0, 0, 'h10A, 1, 32'd1);
    prog = '{8'h41, 8'h01, 8'h21, 8'h09};
    run("bad_local", 'h100, 1, 0, 1, 5, 'h104, 1, 32'd1);
    prog = '{8'hFF};
    run("bad_op", 'h3F0, 1, 0, 1, 3, 'h3F1, 0, 32'd0);
    prog = '{8'h00};
    run("unreach", 'h200, 1, 0, 1, 1, 'h201, 0, 32'd0);
    prog = '{8'h41, 8'h03, 8'h41, 8'h05, 8'h6B, 8'h41, 8'h03, 8'h6C, 8'h45, 8'h45,
             8'h01, 8'h41, 8'h0C, 8'h41, 8'h0A, 8'h71, 8'h72, 8'h41, 8'h0F, 8'h73,
             8'h41, 8'h01, 8'h1A, 8'h0B};
    run("alu_mix", 'h100, 1, 1, 0, 0, 'h118, 1, 32'd6);
    prog = '{8'h20, 8'h07, 8'h0B};
    run("local_init", 'h100, 1, 1, 0, 0, 'h103, 1, 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; entry_pc = '0;
    #1;
    chk("rst_pc", pc, 0);           chk("rst_rd", mif.mem_read_en, 0);
    chk("rst_addr", mif.mem_addr, 0); chk("rst_halt", halted, 0);
    chk("rst_trap", trap, 0);       chk("rst_code", trap_code, 0);
    chk("rst_count", stack_count, 0); chk("rst_top", stack_top, 0);
    #20; @(negedge clk); rst = 1'b0;

    rnd_mode = 0; suite();
    rnd_mode = 1; suite();

    cur_test = "rst_imm";
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    prog = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
    load('h100);
    @(negedge clk); entry_pc = 'h100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(pc == 'h103 && mif.mem_read_en) && cyc < 500) begin @(negedge clk); cyc++; end
    chk("reach_imm", {pc == 'h103, mif.mem_read_en}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("pc", pc, 0);             chk("rd", mif.mem_read_en, 0);
    chk("addr", mif.mem_addr, 0); chk("halt", halted, 0);
    chk("trap", trap, 0);         chk("code", trap_code, 0);
    chk("count", stack_count, 0); chk("top", stack_top, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_rd", mif.mem_read_en, 0);
    chk("idle_pc", pc, 0);

    rnd_mode = 0;
    prog = '{8'h41, 8'h05, 8'h41, 8'h07, 8'h6A, 8'h0B};
    run("after_rst", 'h100, 0, 1, 0, 0, 'h106, 1, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
